tree_deserializer: RTL and testbench

//  Receive end of the serial link driven by tree_serializer / lp_tree_serializer.

---
 rtl/tree_serdes_pkg.sv | 5 +
 rtl/deser_shift_reg.sv | 22 ++
 rtl/tree_deserializer.sv | 71 +++++++
 tb/tb_tree_deserializer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/tree_serdes_pkg.sv
// tree_serdes_pkg: shared word width and deserializer state encoding for the tree serial link.
package tree_serdes_pkg;
    localparam int SERDES_WIDTH = 8;
    typedef enum logic {IDLE, SHIFT} deser_state_t;
endpackage

// File: rtl/deser_shift_reg.sv
// deser_shift_reg: serial-in shift register; next_o is the word as it will look after this cycle's shift.
module deser_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] next_o
);
    logic [WIDTH-1:0] data_q, data_d, first;
    always_comb begin
        next_o = MSB_FIRST ? {data_q[WIDTH-2:0], bit_i} : {bit_i, data_q[WIDTH-1:1]};
        first  = MSB_FIRST ? {{(WIDTH-1){1'b0}}, bit_i} : {bit_i, {(WIDTH-1){1'b0}}};
        data_d = load_i ? first : shift_i ? next_o : data_q;
    end
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) data_q <= '0;
        else       data_q <= data_d;
endmodule

// File: rtl/tree_deserializer.sv
// tree_deserializer: FRAME-aligned serial-to-parallel receiver that free-runs on word boundaries once locked.
module tree_deserializer
    import tree_serdes_pkg::*;
#(
    parameter int WIDTH     = SERDES_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             SERIAL_IN,
    input  logic             FRAME,
    output logic [WIDTH-1:0] PAR_OUT,
    output logic             PAR_VALID,
    output logic             ALIGN_ERR,
    output logic             LOCKED
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    deser_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] par_q, par_d, word;
    logic valid_q, valid_d, err_q, err_d, load, shift;
    deser_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr (
        .clk_i(CLK), .rst_i(RESET), .load_i(load), .shift_i(shift),
        .bit_i(SERIAL_IN), .next_o(word)
    );
    // A FRAME anywhere but the expected boundary restarts the word; the final-bit cycle counts as mid-word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        if (state_q == IDLE) begin
            if (FRAME) begin
                load    = 1'b1;
                cnt_d   = CW'(1);
                state_d = SHIFT;
            end
        end else if (FRAME && cnt_q != '0) begin
            load  = 1'b1;
            cnt_d = CW'(1);
            err_d = 1'b1;
        end else begin
            shift   = 1'b1;
            valid_d = cnt_q == LAST;
            par_d   = valid_d ? word : par_q;
            cnt_d   = valid_d ? '0 : cnt_q + 1'b1;
        end
    end
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            par_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    assign PAR_OUT   = par_q;
    assign PAR_VALID = valid_q;
    assign ALIGN_ERR = err_q;
    assign LOCKED    = state_q == SHIFT;
endmodule

// File: tb/tb_tree_deserializer.sv
// tb_tree_deserializer: scoreboard bench for an 8-bit MSB-first and a 4-bit LSB-first receiver.
module tb_tree_deserializer;
    typedef struct {
        logic [7:0] w;
        int         cyc;
    } exp_t;

    logic CLK = 1'b0, RESET = 1'b1;
    logic ser8 = 1'b0, frm8 = 1'b0, ser4 = 1'b0, frm4 = 1'b0;
    logic [7:0] par8;
    logic [3:0] par4;
    logic valid8, err8, locked8, valid4, err4, locked4;
    int cyc = 0, n_chk = 0, n_err = 0;
    exp_t q8[$], q4[$];
    int e8[$];

    tree_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
        .CLK(CLK), .RESET(RESET), .SERIAL_IN(ser8), .FRAME(frm8),
        .PAR_OUT(par8), .PAR_VALID(valid8), .ALIGN_ERR(err8), .LOCKED(locked8)
    );
    tree_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4 (
        .CLK(CLK), .RESET(RESET), .SERIAL_IN(ser4), .FRAME(frm4),
        .PAR_OUT(par4), .PAR_VALID(valid4), .ALIGN_ERR(err4), .LOCKED(locked4)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic send_bit(input bit sel4, input logic b, input logic f);
        @(negedge CLK);
        if (sel4) begin ser4 = b; frm4 = f; end
        else      begin ser8 = b; frm8 = f; end
        @(posedge CLK);
        #1;
        frm8 = 1'b0;
        frm4 = 1'b0;
    endtask

    task automatic send_word(input bit sel4, input logic [7:0] w, input bit f, input bit mid);
        int n;
        n = sel4 ? 4 : 8;
        for (int i = 0; i < n; i++) begin
            send_bit(sel4, sel4 ? w[i] : w[7-i], f && i == 0);
            if (f && mid && i == 0) e8.push_back(cyc);
            check(sel4 ? "lock4" : "lock8", sel4 ? locked4 : locked8, 1);
        end
        if (sel4) q4.push_back('{w, cyc});
        else      q8.push_back('{w, cyc});
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #2 RESET = 1'b1;
        #1 check("rst_mid", {par8, valid8, err8, locked8}, 0);
        @(negedge CLK);
        #2 RESET = 1'b0;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (!RESET) begin
            if (valid8) begin
                if (q8.size() == 0) check("spur_valid8", valid8, 0);
                else begin
                    e = q8.pop_front();
                    check("word8", par8, e.w);
                    check("lat8", cyc, e.cyc);
                end
            end
            if (err8) begin
                if (e8.size() == 0) check("spur_err8", err8, 0);
                else check("err_lat8", cyc, e8.pop_front());
            end
            if (valid4) begin
                if (q4.size() == 0) check("spur_valid4", valid4, 0);
                else begin
                    e = q4.pop_front();
                    check("word4", par4, e.w[3:0]);
                    check("lat4", cyc, e.cyc);
                end
            end
            if (err4) check("spur_err4", err4, 0);
            if (valid8 && err8) check("excl8", 1, 0);
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            ser8 = 1'($urandom); frm8 = 1'($urandom);
            ser4 = 1'($urandom); frm4 = 1'($urandom);
            #1;
            check("rst8", {par8, valid8, err8, locked8}, 0);
            check("rst4", {par4, valid4, err4, locked4}, 0);
        end
        @(negedge CLK);
        RESET = 1'b0; frm8 = 1'b0; frm4 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send_bit(0, 1'($urandom), 1'b0);
            check("idle_lock8", locked8, 0);
        end
        send_word(0, 8'hAF, 1, 0);
        send_word(0, 8'hAF, 1, 0);
        send_word(0, 8'h00, 0, 0);
        send_word(0, 8'h5A, 0, 0);
        for (int i = 0; i < 3; i++) send_bit(0, 1'($urandom), 1'b0);
        send_word(0, 8'h3C, 1, 1);
        send_word(0, 8'hC3, 0, 0);
        for (int i = 0; i < 7; i++) send_bit(0, 1'($urandom), 1'b0);
        send_word(0, 8'h96, 1, 1);
        for (int i = 0; i < 5; i++) send_bit(0, 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 12; i++) begin
            send_bit(0, 1'($urandom), 1'b0);
            check("post_rst_lock8", locked8, 0);
        end
        send_word(0, 8'h71, 1, 0);
        send_bit(0, 1'b0, 1'b0);
        do_reset();
        send_word(1, 8'h0D, 1, 0);
        send_word(1, 8'h06, 0, 0);
        repeat (2) @(negedge CLK);
        #1;
        check("pend8", q8.size(), 0);
        check("pend4", q4.size(), 0);
        check("pend_err8", e8.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
